// File: rtl/capture_event_pipe.sv
// Event capture stage: pops packed words from the input event FIFO, decodes them into
// timestep markers or range-checked spike events, and counts accepted/dropped events.
module capture_event_pipe #(
    parameter int DATA_WIDTH          = 21,
    parameter int IMG_HEIGHT          = 32,
    parameter int IMG_WIDTH           = 32,
    parameter int BITS_PER_COORDINATE = 8,
    parameter int IN_CHANNELS         = 4,
    parameter int FIFO_READ_LATENCY   = 1,
    parameter bit DROP_EMPTY_SPIKES   = 1'b1,
    parameter int CNT_WIDTH           = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           fifo_empty,
    output logic                           fifo_read_en,
    input  logic [DATA_WIDTH-1:0]          fifo_read_data,
    output logic                           event_valid,
    input  logic                           event_ready,
    output logic [BITS_PER_COORDINATE-1:0] event_x,
    output logic [BITS_PER_COORDINATE-1:0] event_y,
    output logic [IN_CHANNELS-1:0]         event_spikes,
    output logic                           timestep_valid,
    input  logic                           timestep_ready,
    input  logic                           clear_count,
    output logic [CNT_WIDTH-1:0]           event_count,
    output logic [CNT_WIDTH-1:0]           drop_count
);

    localparam int B      = BITS_PER_COORDINATE;
    localparam int C      = IN_CHANNELS;
    localparam int TS_BIT = C + 2 * B;

    localparam logic [B:0] X_LIMIT  = (B + 1)'(IMG_WIDTH);
    localparam logic [B:0] Y_LIMIT  = (B + 1)'(IMG_HEIGHT);
    localparam logic [1:0] WAIT_END = 2'(FIFO_READ_LATENCY - 1);

    if (DATA_WIDTH < TS_BIT + 1) begin : g_bad_data_width
        $error("capture_event_pipe: DATA_WIDTH too small for the event word layout");
    end
    if (IMG_WIDTH > 2 ** B || IMG_HEIGHT > 2 ** B) begin : g_bad_image_size
        $error("capture_event_pipe: image size does not fit the coordinate fields");
    end
    if (FIFO_READ_LATENCY < 1 || FIFO_READ_LATENCY > 2) begin : g_bad_latency
        $error("capture_event_pipe: FIFO_READ_LATENCY must be 1 or 2");
    end
    if (DATA_WIDTH > TS_BIT + 1) begin : g_upper_bits
        logic unused_upper;
        assign unused_upper = ^fifo_read_data[DATA_WIDTH-1:TS_BIT+1];
    end

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        DECODE,
        OUT_EVT,
        OUT_TS
    } state_t;

    state_t          state, state_next;
    logic [TS_BIT:0] cap_q;
    logic [1:0]      wait_cnt;

    logic            capture, drop, load_evt, load_ts, evt_done, ts_done;

    logic [C-1:0]    cap_spikes;
    logic [B-1:0]    cap_x, cap_y;
    logic            cap_ts, out_of_range, no_spikes;

    assign cap_spikes   = cap_q[C-1:0];
    assign cap_y        = cap_q[C+B-1:C];
    assign cap_x        = cap_q[C+2*B-1:C+B];
    assign cap_ts       = cap_q[TS_BIT];
    assign out_of_range = ({1'b0, cap_x} >= X_LIMIT) || ({1'b0, cap_y} >= Y_LIMIT);
    assign no_spikes    = DROP_EMPTY_SPIKES && (cap_spikes == '0);

    // NOTE: every output of this block gets a default before the case, so no path can infer a latch.
    always_comb begin
        state_next   = state;
        fifo_read_en = 1'b0;
        capture      = 1'b0;
        drop         = 1'b0;
        load_evt     = 1'b0;
        load_ts      = 1'b0;
        evt_done     = 1'b0;
        ts_done      = 1'b0;
        unique case (state)
            IDLE: begin
                // Gating with rst keeps a word from being popped while the pipe is being cleared.
                if (!fifo_empty && !rst) begin
                    fifo_read_en = 1'b1;
                    state_next   = WAIT;
                end
            end
            WAIT: begin
                if (wait_cnt == WAIT_END) begin
                    capture    = 1'b1;
                    state_next = DECODE;
                end
            end
            DECODE: begin
                if (cap_ts) begin
                    load_ts    = 1'b1;
                    state_next = OUT_TS;
                end else if (out_of_range || no_spikes) begin
                    drop       = 1'b1;
                    state_next = IDLE;
                end else begin
                    load_evt   = 1'b1;
                    state_next = OUT_EVT;
                end
            end
            OUT_EVT: begin
                if (event_ready) begin
                    evt_done   = 1'b1;
                    state_next = IDLE;
                end
            end
            OUT_TS: begin
                if (timestep_ready) begin
                    ts_done    = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_q          <= '0;
            wait_cnt       <= '0;
            event_valid    <= 1'b0;
            event_x        <= '0;
            event_y        <= '0;
            event_spikes   <= '0;
            timestep_valid <= 1'b0;
        end else begin
            if (state == WAIT && !capture) wait_cnt <= wait_cnt + 2'd1;
            else                           wait_cnt <= '0;

            if (capture) cap_q <= fifo_read_data[TS_BIT:0];

            if (load_evt) begin
                event_valid  <= 1'b1;
                event_x      <= cap_x;
                event_y      <= cap_y;
                event_spikes <= cap_spikes;
            end else if (evt_done) begin
                event_valid  <= 1'b0;
            end

            if (load_ts)      timestep_valid <= 1'b1;
            else if (ts_done) timestep_valid <= 1'b0;
        end
    end

    // Saturating counters; a clear wins over an increment in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || clear_count) begin
            event_count <= '0;
            drop_count  <= '0;
        end else begin
            if (evt_done && !(&event_count)) event_count <= event_count + CNT_WIDTH'(1);
            if (drop && !(&drop_count))      drop_count  <= drop_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_capture_event_pipe.sv
// Directed bench for capture_event_pipe: FIFO models with read latency, a scoreboard of
// expected markers/events, and a second instance with two-cycle latency and 2-bit counters.
module tb_capture_event_pipe;

    localparam int DW = 21;

    typedef struct packed {
        logic       ts;
        logic [7:0] x;
        logic [7:0] y;
        logic [3:0] sp;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic          a_empty, a_ren, a_ev, a_er, a_tv, a_tr, a_clr;
    logic [DW-1:0] a_data;
    logic [7:0]    a_x, a_y;
    logic [3:0]    a_sp;
    logic [15:0]   a_ec, a_dc;

    logic          b_empty, b_ren, b_ev, b_er, b_tv, b_tr, b_clr;
    logic [DW-1:0] b_data, b_d1;
    logic [7:0]    b_x, b_y;
    logic [3:0]    b_sp;
    logic [1:0]    b_ec, b_dc;

    capture_event_pipe #(
        .DATA_WIDTH(DW), .IMG_HEIGHT(32), .IMG_WIDTH(32), .BITS_PER_COORDINATE(8),
        .IN_CHANNELS(4), .FIFO_READ_LATENCY(1), .DROP_EMPTY_SPIKES(1'b1), .CNT_WIDTH(16)
    ) u_dut_a (
        .clk(clk), .rst(rst), .fifo_empty(a_empty), .fifo_read_en(a_ren),
        .fifo_read_data(a_data), .event_valid(a_ev), .event_ready(a_er),
        .event_x(a_x), .event_y(a_y), .event_spikes(a_sp),
        .timestep_valid(a_tv), .timestep_ready(a_tr), .clear_count(a_clr),
        .event_count(a_ec), .drop_count(a_dc)
    );

    capture_event_pipe #(
        .DATA_WIDTH(DW), .IMG_HEIGHT(32), .IMG_WIDTH(32), .BITS_PER_COORDINATE(8),
        .IN_CHANNELS(4), .FIFO_READ_LATENCY(2), .DROP_EMPTY_SPIKES(1'b1), .CNT_WIDTH(2)
    ) u_dut_b (
        .clk(clk), .rst(rst), .fifo_empty(b_empty), .fifo_read_en(b_ren),
        .fifo_read_data(b_data), .event_valid(b_ev), .event_ready(b_er),
        .event_x(b_x), .event_y(b_y), .event_spikes(b_sp),
        .timestep_valid(b_tv), .timestep_ready(b_tr), .clear_count(b_clr),
        .event_count(b_ec), .drop_count(b_dc)
    );

    int vectors     = 0;
    int miscompares = 0;
    int exp_evt     = 0;
    int exp_drop    = 0;

    logic [DW-1:0] a_fifo[$];
    logic [DW-1:0] b_fifo[$];
    exp_t          exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // FIFO models: data appears FIFO_READ_LATENCY cycles after the read_en cycle, X otherwise.
    always @(posedge clk) begin
        if (a_ren) begin
            a_data  <= a_fifo.pop_front();
            a_empty <= (a_fifo.size() == 0);
        end else begin
            a_data  <= 'x;
        end
        if (b_ren) begin
            b_d1    <= b_fifo.pop_front();
            b_empty <= (b_fifo.size() == 0);
        end else begin
            b_d1    <= 'x;
        end
        b_data <= b_d1;
    end

    // Scoreboard: every handshake on either channel must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst) begin
            check("valid_exclusive", 32'(a_ev & a_tv), 32'd0);
            if ((a_ev && a_er) || (a_tv && a_tr)) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_output", 32'({a_ev, a_tv}), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_kind", 32'(a_tv), 32'(e.ts));
                    if (!e.ts) check("sb_event_fields", 32'({a_x, a_y, a_sp}), 32'({e.x, e.y, e.sp}));
                end
            end
        end
    end

    task automatic push_a(input logic [DW-1:0] w);
        exp_t e;
        e = {w[20], w[19:12], w[11:4], w[3:0]};
        if (e.ts) begin
            exp_q.push_back({1'b1, 20'd0});
        end else if (e.x >= 8'd32 || e.y >= 8'd32 || e.sp == 4'd0) begin
            exp_drop++;
        end else begin
            exp_q.push_back(e);
            exp_evt++;
        end
        a_fifo.push_back(w);
        a_empty = 1'b0;
    endtask

    task automatic push_b(input logic [DW-1:0] w);
        b_fifo.push_back(w);
        b_empty = 1'b0;
    endtask

    // Waits at negedges for a valid output; returns how many negedges it took.
    task automatic wait_valid(input bit use_b, input bit ts, input string tag, output int n);
        n = 0;
        while (!(use_b ? b_ev : (ts ? a_tv : a_ev)) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, 32'(n >= 50), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [19:0] held;

        rst = 1'b1;
        a_empty = 1'b1; a_er = 1'b1; a_tr = 1'b1; a_clr = 1'b0;
        b_empty = 1'b1; b_er = 1'b1; b_tr = 1'b1; b_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs_a", 32'({a_ev, a_tv, a_ren, a_x, a_y, a_sp}), 32'd0);
        check("reset_counts_a", {a_ec, a_dc}, 32'd0);
        check("reset_outputs_b", 32'({b_ev, b_tv, b_ren, b_ec, b_dc}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 1: single event, latency LAT+2 from the read_en cycle
        push_a(21'h0507A);
        #1;
        check("t1_read_en", 32'(a_ren), 32'd1);
        wait_valid(1'b0, 1'b0, "t1_event", n);
        check("t1_latency", 32'(n), 32'd3);
        @(negedge clk);
        check("t1_event_count", 32'(a_ec), 32'd1);
        check("t1_valid_cleared", 32'(a_ev), 32'd0);

        // 2: drops (x out of range, empty spikes, y out of range) around an edge-of-image event
        push_a({1'b0, 8'd40, 8'd1, 4'h1});
        push_a({1'b0, 8'd2, 8'd2, 4'h0});
        push_a({1'b0, 8'd31, 8'd31, 4'hF});
        push_a({1'b0, 8'd3, 8'd32, 4'h1});
        repeat (30) @(negedge clk);
        check("t2_drop_count", 32'(a_dc), 32'(exp_drop));
        check("t2_event_count", 32'(a_ec), 32'(exp_evt));
        check("t2_fifo_drained", 32'(a_empty), 32'd1);

        // 3: markers in FIFO order; the event waits behind an unaccepted marker
        a_tr = 1'b0;
        push_a(21'h100000);
        push_a(21'h1FFFF0);
        push_a(21'h0A0B3);
        wait_valid(1'b0, 1'b1, "t3_marker", n);
        repeat (5) begin
            @(negedge clk);
            check("t3_marker_held", 32'({a_tv, a_ev}), 32'b10);
        end
        a_tr = 1'b1;
        repeat (20) @(negedge clk);
        check("t3_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        // 4: backpressure holds the event stable and blocks further reads
        a_er = 1'b0;
        push_a(21'h1F1F1);
        push_a(21'h02031);
        wait_valid(1'b0, 1'b0, "t4_event", n);
        held = {a_x, a_y, a_sp};
        repeat (10) begin
            @(negedge clk);
            check("t4_hold_fields", 32'({a_ev, a_x, a_y, a_sp}), 32'({1'b1, held}));
            check("t4_no_read", 32'(a_ren), 32'd0);
        end
        a_er = 1'b1;
        repeat (15) @(negedge clk);
        check("t4_event_count", 32'(a_ec), 32'(exp_evt));
        check("t4_scoreboard_empty", 32'(exp_q.size()), 32'd0);

        // clear_count wins over a same-cycle increment
        a_er = 1'b0;
        push_a(21'h04045);
        wait_valid(1'b0, 1'b0, "clr_event", n);
        a_er = 1'b1;
        a_clr = 1'b1;
        @(negedge clk);
        a_clr = 1'b0;
        exp_evt = 0;
        exp_drop = 0;
        check("clr_counts", {a_ec, a_dc}, 32'd0);

        // 6: reset while a popped word is in WAIT
        push_a({1'b0, 8'd40, 8'd1, 4'h1});
        repeat (8) @(negedge clk);
        check("t6_pre_drop", 32'(a_dc), 32'd1);
        push_a(21'h05055);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_reset_outputs", 32'({a_ev, a_tv, a_ren, a_x, a_y, a_sp}), 32'd0);
        check("t6_reset_counts", {a_ec, a_dc}, 32'd0);
        exp_q.delete();
        exp_evt = 0;
        exp_drop = 0;
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            check("t6_word_discarded", 32'({a_ev, a_tv}), 32'd0);
        end
        push_a(21'h0507A);
        wait_valid(1'b0, 1'b0, "t6_restart", n);
        check("t6_restart_latency", 32'(n), 32'd3);
        repeat (3) @(negedge clk);
        check("t6_event_count", 32'(a_ec), 32'd1);

        // 5: FIFO_READ_LATENCY=2 and 2-bit saturating counter
        push_b(21'h0507A);
        for (int i = 1; i <= 4; i++) push_b({1'b0, 8'(i), 8'(i), 4'h1});
        wait_valid(1'b1, 1'b0, "t5_event", n);
        check("t5_latency", 32'(n), 32'd4);
        check("t5_fields", 32'({b_x, b_y, b_sp}), 32'h0507A);
        repeat (40) @(negedge clk);
        check("t5_saturated_count", 32'(b_ec), 32'd3);
        check("t5_drop_count", 32'(b_dc), 32'd0);

        check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
